// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-PC sequencer with boot, trap, halt handling and retire count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        imem_error_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    output logic [1:0]  state_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_IMEM     = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [1:0]  cause_q;
    logic [31:0] cnt_q;
    logic [31:0] pc_seq_d;
    logic [31:0] cnt_inc_d;

    assign pc_seq_d  = pc_q + 32'd4;
    assign cnt_inc_d = cnt_q + 32'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cause_q <= CAUSE_NONE;
            cnt_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (imem_error_i) begin
                        // Faulted fetch never retires.
                        pc_q    <= TRAP_PC;
                        cause_q <= CAUSE_IMEM;
                        state_q <= ST_TRAP;
                    end else if (halt_req_i) begin
                        state_q <= ST_HALT;
                        cnt_q   <= cnt_inc_d;
                    end else if (stall_i) begin
                        state_q <= ST_RUN;
                    end else if (redirect_valid_i) begin
                        cnt_q <= cnt_inc_d;
                        if (redirect_pc_i[1:0] == 2'b00) begin
                            pc_q <= redirect_pc_i;
                        end else begin
                            pc_q    <= TRAP_PC;
                            cause_q <= CAUSE_MISALIGN;
                            state_q <= ST_TRAP;
                        end
                    end else begin
                        pc_q  <= pc_seq_d;
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_TRAP: state_q <= ST_RUN;
                ST_HALT: begin
                    // The halting instruction already retired; resume skips past it.
                    if (resume_i) begin
                        pc_q    <= pc_seq_d;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign state_o       = state_q;
    assign trap_cause_o  = cause_q;
    assign retire_cnt_o  = cnt_q;
    assign fetch_valid_o = (state_q == ST_RUN);

endmodule

`default_nettype wire
